// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the multi-channel FIR MAC engine.
// Width derivations keep the accumulator wide enough that no tap sequence can wrap.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } fir_state_e;

    function automatic int tap_w(input int ntaps);
        return $clog2(ntaps);
    endfunction

    function automatic int bank_w(input int nbank);
        return (nbank > 1) ? $clog2(nbank) : 1;
    endfunction

    function automatic int acc_w(input int data_w, input int coef_w, input int ntaps);
        return data_w + coef_w + $clog2(ntaps);
    endfunction

    // Round half up, shift out the fractional bits, clamp to the signed data_w range.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                     input int frac,
                                                     input int data_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (frac > 0) begin
            r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        end else begin
            r = acc;
        end
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (r > hi) begin
            round_sat = hi;
        end else if (r < lo) begin
            round_sat = lo;
        end else begin
            round_sat = r;
        end
    endfunction

endpackage

// File: rtl/fir_mac_engine_if.sv
// Sample-queue, coefficient-ROM and result bundle of the FIR MAC engine.
// master = controlling/feeding side, slave = the engine itself.
interface fir_mac_engine_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 1021,
    parameter int NCH    = 2,
    parameter int NBANK  = 4
) ();
    localparam int TAP_W  = fir_pkg::tap_w(NTAPS);
    localparam int BANK_W = fir_pkg::bank_w(NBANK);

    logic                      start;
    logic [BANK_W-1:0]         bank;
    logic [NCH*DATA_W-1:0]     smpl_in;
    logic [COEF_W-1:0]         coef_data;
    logic                      seq_req;
    logic [BANK_W+TAP_W-1:0]   coef_addr;
    logic                      busy;
    logic                      done;
    logic [NCH*DATA_W-1:0]     smpl_out;

    modport master (
        output start, bank, smpl_in, coef_data,
        input  seq_req, coef_addr, busy, done, smpl_out
    );

    modport slave (
        input  start, bank, smpl_in, coef_data,
        output seq_req, coef_addr, busy, done, smpl_out
    );
endinterface

// File: rtl/fir_mac_lane.sv
// One channel of the FIR engine: accumulator, round/saturate and result register.
// The result is taken from the next-accumulator value so it includes the final product.
module fir_mac_lane
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int FRAC   = 15,
    parameter int ACC_W  = 42
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     acc_en,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] smpl,
    input  logic signed [COEF_W-1:0] coef,
    output logic        [DATA_W-1:0] result
);
    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [ACC_W-1:0]  acc_nxt_s;
    logic signed [63:0]       acc64_s;
    logic signed [DATA_W-1:0] res_s;
    logic signed [ACC_W-1:0]  acc_r;
    logic        [DATA_W-1:0] result_r;

    assign prod_s = smpl * coef;

    // Next accumulator value and its rounded, saturated image.
    always_comb begin
        prod_ext_s = {{(ACC_W - PROD_W){prod_s[PROD_W-1]}}, prod_s};
        if (acc_en) begin
            acc_nxt_s = acc_r + prod_ext_s;
        end else begin
            acc_nxt_s = acc_r;
        end
        acc64_s = {{(64 - ACC_W){acc_nxt_s[ACC_W-1]}}, acc_nxt_s};
        res_s   = DATA_W'(round_sat(acc64_s, FRAC, DATA_W));
    end

    // Accumulator and held output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {ACC_W{1'b0}};
            result_r <= {DATA_W{1'b0}};
        end else begin
            if (clr) begin
                acc_r <= {ACC_W{1'b0}};
            end else begin
                acc_r <= acc_nxt_s;
            end
            if (load) begin
                result_r <= res_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign result = result_r;

endmodule

// File: rtl/fir_mac_engine.sv
// Multi-channel FIR multiply-accumulate engine: sequences NTAPS taps of one coefficient
// bank against NCH sample streams and emits rounded, saturated results with a done pulse.
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int FRAC   = 15,
    parameter int NTAPS  = 1021,
    parameter int NCH    = 2,
    parameter int NBANK  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    fir_mac_engine_if.slave  bus
);
    localparam int TAP_W  = tap_w(NTAPS);
    localparam int BANK_W = bank_w(NBANK);
    localparam int ACC_W  = acc_w(DATA_W, COEF_W, NTAPS);
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NTAPS - 1);
    localparam logic [TAP_W-1:0] TAP_ONE  = TAP_W'(1);

    fir_state_e                state_r;
    logic [TAP_W-1:0]          tap_r;
    logic [BANK_W-1:0]         bank_r;
    logic                      seq_req_r;
    logic                      busy_r;
    logic                      done_r;
    logic [BANK_W+TAP_W-1:0]   coef_addr_r;
    logic [TAP_W-1:0]          tap_inc_s;
    logic                      clr_s;
    logic                      acc_en_s;
    logic                      load_s;
    logic [NCH*DATA_W-1:0]     smpl_out_s;

    // Lane controls; data for tap k arrives one cycle after its address, so tap 0's
    // RUN cycle only fills the pipeline and FLUSH absorbs the last product.
    always_comb begin
        tap_inc_s = tap_r + TAP_ONE;
        clr_s     = 1'b0;
        acc_en_s  = 1'b0;
        load_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clr_s = bus.start;
            end
            ST_RUN: begin
                if (tap_r != {TAP_W{1'b0}}) begin
                    acc_en_s = 1'b1;
                end else begin
                    acc_en_s = 1'b0;
                end
            end
            ST_FLUSH: begin
                acc_en_s = 1'b1;
                load_s   = 1'b1;
            end
            default: begin
                clr_s    = 1'b0;
                acc_en_s = 1'b0;
                load_s   = 1'b0;
            end
        endcase
    end

    // Sequencing FSM with tap counter, latched bank and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            tap_r       <= {TAP_W{1'b0}};
            bank_r      <= {BANK_W{1'b0}};
            seq_req_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            coef_addr_r <= {(BANK_W + TAP_W){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    tap_r  <= {TAP_W{1'b0}};
                    if (bus.start) begin
                        state_r     <= ST_RUN;
                        bank_r      <= bus.bank;
                        seq_req_r   <= 1'b1;
                        busy_r      <= 1'b1;
                        coef_addr_r <= {bus.bank, {TAP_W{1'b0}}};
                    end else begin
                        seq_req_r   <= 1'b0;
                        busy_r      <= 1'b0;
                        coef_addr_r <= {(BANK_W + TAP_W){1'b0}};
                    end
                end
                ST_RUN: begin
                    if (tap_r == TAP_LAST) begin
                        state_r     <= ST_FLUSH;
                        seq_req_r   <= 1'b0;
                        coef_addr_r <= {(BANK_W + TAP_W){1'b0}};
                    end else begin
                        tap_r       <= tap_inc_s;
                        coef_addr_r <= {bank_r, tap_inc_s};
                    end
                end
                ST_FLUSH: begin
                    state_r <= ST_DONE;
                    done_r  <= 1'b1;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    tap_r   <= {TAP_W{1'b0}};
                end
                default: begin
                    state_r     <= ST_IDLE;
                    tap_r       <= {TAP_W{1'b0}};
                    seq_req_r   <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    coef_addr_r <= {(BANK_W + TAP_W){1'b0}};
                end
            endcase
        end
    end

    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_lane
            fir_mac_lane #(
                .DATA_W (DATA_W),
                .COEF_W (COEF_W),
                .FRAC   (FRAC),
                .ACC_W  (ACC_W)
            ) u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr    (clr_s),
                .acc_en (acc_en_s),
                .load   (load_s),
                .smpl   (bus.smpl_in[c*DATA_W +: DATA_W]),
                .coef   (bus.coef_data),
                .result (smpl_out_s[c*DATA_W +: DATA_W])
            );
        end
    endgenerate

    assign bus.seq_req   = seq_req_r;
    assign bus.coef_addr = coef_addr_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.smpl_out  = smpl_out_s;

endmodule

// File: doc/fir_mac_engine.md
Name: fir_mac_engine

Overview:
Parametrised multi-channel FIR multiply-accumulate engine, the successor to the fixed two-channel, single-ROM band filters in the equalizer datapath. One start pulse triggers a full NTAPS-long convolution: the engine requests samples from the circular queue and reads coefficients from an external bank-selectable ROM. Per channel it produces a rounded, saturated result with a done pulse. It sits between the sample queues and the band-gain/summing stage, one instance per band.

Parameters:
DATA_W, 16, sample and result width (signed)
COEF_W, 16, coefficient width (signed)
FRAC, 15, coefficient fractional bits; result = accum >>> FRAC
NTAPS, 1021, taps per convolution (>=2)
NCH, 2, parallel channels sharing one coefficient stream
NBANK, 4, coefficient banks in ROM (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  begin convolution; honoured only in IDLE
bank  in  max(1,clog2(NBANK))  coefficient bank; latched on accepted start
smpl_in  in  NCH*DATA_W  queue samples; channel c at [c*DATA_W +: DATA_W]; valid 1 cycle after seq_req
coef_data  in  COEF_W  ROM read data; 1-cycle read latency
seq_req  out  1  sequencing request to queues; high for exactly NTAPS cycles
coef_addr  out  BANK_W+TAP_W  {bank_latched, tap}; TAP_W=clog2(NTAPS)
busy  out  1  high from the cycle after accepted start through the done cycle
done  out  1  one-cycle pulse; smpl_out updated the same cycle
smpl_out  out  NCH*DATA_W  registered results, held until the next done

Behaviour:
- Reset: state IDLE; seq_req, busy, done = 0; coef_addr = 0; all accumulators = 0; smpl_out = 0.
- Accumulator width ACC_W = DATA_W+COEF_W+clog2(NTAPS); products are full-precision signed; no wrap possible.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE: start=1 -> RUN. Latch bank, tap=0, clear all accumulators. start while not IDLE is ignored; no queuing.
- RUN: seq_req=1; coef_addr={bank_l,tap}; tap increments each cycle. Each cycle accumulates coef_data*smpl_in[c] from the previous address; the first RUN cycle adds nothing (pipeline fill). When tap==NTAPS-1 -> FLUSH.
- FLUSH: seq_req=0; accumulate the last product -> DONE.
- DONE: per channel r = (accum + 2^(FRAC-1)) >>> FRAC (round half up). Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and register into smpl_out. done=1 -> IDLE.
- Latency: start sampled at edge t; done high in cycle t+NTAPS+2; next start accepted from cycle t+NTAPS+3.
- tap never exceeds NTAPS-1; coef_addr returns to 0 in IDLE.
- A bank change after the accepted start has no effect until the next start.
- Reset mid-operation: immediate return to reset state; partial results discarded; smpl_out = 0.

Decomposition:
- Package fir_pkg: ACC_W/TAP_W/BANK_W derivation functions, FSM state enum, saturate-and-round function.
- Sub-module fir_mac_lane: one channel's accumulator, clear, round/saturate and output register. Instantiated NCH times by generate. The top keeps the FSM, tap counter and address.

Test Plan:
- Reset: assert rst_n=0 mid-RUN -> seq_req=busy=done=0, smpl_out=0 immediately; next start runs normally.
- Impulse/rounding (NTAPS=4, NCH=2, bank0 coefs 0x4000,0x2000,0x1000,0x0800): ch0 samples 0x7FFF,0,0,0; ch1 samples 0,0,0,0x7FFF -> ch0=0x4000 (half rounded up), ch1=0x0800.
- Saturation (NTAPS=4): all coefs 0x7FFF, ch0 all 0x7FFF -> 0x7FFF; ch1 all 0x8000 -> 0x8000.
- Timing/handshake (NTAPS=4): start at edge t -> seq_req high t+1..t+4; done high only in t+6; start pulses during busy -> ignored, exactly one done.
- Bank select (NBANK=4): start with bank=2, change bank to 1 during RUN -> coef_addr upper bits = 2 throughout; result uses bank-2 coefs.
- Back-to-back: start asserted in cycle after done -> accepted; accumulators cleared; second result independent of the first.
